// File: rtl/deja_glitch_trigger.sv
// deja_glitch_trigger
//   Upstream stage of deja_glitch_power; its run_o feeds that block's run_i.
//   It watches an external target event (trig_i) and waits a programmable
//   delay. It then raises run_o for a programmable width. An optional
//   hold-off and automatic re-arm allow repeated glitch attempts.
//
// Ports
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   stb_i    bus strobe
//   we_i     bus write enable (1 = write)
//   adr_i    register address (4 bits)
//   dat_i    write data (8 bits)
//   ack_o    bus acknowledge, one cycle per access
//   dat_o    read data, valid while ack_o=1 and held otherwise
//   trig_i   asynchronous target event input
//   run_o    glitch run request (registered)
//   armed_o  high while in ARMED (registered)
//
// Register map
//   0 CTRL     bit0 ARM, bit1 EDGE (1 = falling), bit2 AUTO, bit3 SOFT (wo)
//   1 DELAY_LO 2 DELAY_HI 3 WIDTH (0 = 256) 4 HOLDOFF
//   5 STATUS   bit0 armed, bit1 in DELAY, bit2 run_o, bit3 DONE, [7:5] state
//   6 COUNT    completed pulses; any write clears it
module deja_glitch_trigger #(
  parameter logic [15:0] DELAY_RST = 16'd0,
  parameter logic [7:0]  WIDTH_RST = 8'd1,
  parameter logic [7:0]  HOLD_RST  = 8'd0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [3:0] adr_i,
  input  logic [7:0] dat_i,
  output logic       ack_o,
  output logic [7:0] dat_o,
  input  logic       trig_i,
  output logic       run_o,
  output logic       armed_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_FIRE  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t      state;

  // Programmed registers.
  logic [15:0] delay_reg;
  logic [7:0]  width_reg;
  logic [7:0]  hold_reg;
  logic        arm;
  logic        edge_fall;
  logic        auto_en;
  logic        done;
  logic [7:0]  count;

  // Working counters, loaded when a shot is triggered.
  logic [15:0] dcnt;
  logic [8:0]  wcnt;
  logic [7:0]  hcnt;
  logic [7:0]  hold_w;

  // Two-flop synchroniser plus one history flop for edge detection.
  logic        s1, s2, s3;

  logic        access;
  logic        wr_en;
  logic        ctrl_wr;
  logic        abort;
  logic        arm_wr;
  logic        soft_wr;
  logic        count_clr;
  logic        evt;
  logic        launch;
  logic        fire_end;
  logic        rearm_pt;
  logic [7:0]  rd_data;

  // An access is serviced on the edge where ack_o rises; the next cycle
  // ack_o is high, which blocks a second service of the same strobe.
  assign access    = stb_i & ~ack_o;
  assign wr_en     = access & we_i;
  assign ctrl_wr   = wr_en && (adr_i == 4'd0);
  assign abort     = ctrl_wr & ~dat_i[0];
  assign arm_wr    = ctrl_wr &  dat_i[0];
  assign soft_wr   = arm_wr  &  dat_i[3];
  assign count_clr = wr_en && (adr_i == 4'd6);

  assign evt = edge_fall ? (~s2 & s3) : (s2 & ~s3);

  // A soft trigger with ARM=1 fires straight from IDLE as well as from
  // ARMED. Events outside ARMED are dropped, not queued. Abort always wins.
  assign launch = ~abort & (((state == ST_ARMED) & (evt | soft_wr)) |
                            ((state == ST_IDLE)  & soft_wr));

  assign fire_end = ~abort & (state == ST_FIRE) & (wcnt == 9'd1);

  assign rearm_pt = (fire_end & (hold_w == 8'd0)) |
                    (~abort & (state == ST_HOLD) & (hcnt == 8'd1));

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so
    // no latch is inferred for unlisted addresses.
    rd_data = 8'h00;
    case (adr_i)
      4'd0:    rd_data = {5'b0, auto_en, edge_fall, arm};
      4'd1:    rd_data = delay_reg[7:0];
      4'd2:    rd_data = delay_reg[15:8];
      4'd3:    rd_data = width_reg;
      4'd4:    rd_data = hold_reg;
      4'd5:    rd_data = {state, 1'b0, done, run_o, state == ST_DELAY, armed_o};
      4'd6:    rd_data = count;
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      run_o     <= 1'b0;
      armed_o   <= 1'b0;
      ack_o     <= 1'b0;
      dat_o     <= 8'h00;
      delay_reg <= DELAY_RST;
      width_reg <= WIDTH_RST;
      hold_reg  <= HOLD_RST;
      arm       <= 1'b0;
      edge_fall <= 1'b0;
      auto_en   <= 1'b0;
      done      <= 1'b0;
      count     <= 8'h00;
      dcnt      <= 16'h0000;
      wcnt      <= 9'h000;
      hcnt      <= 8'h00;
      hold_w    <= 8'h00;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every flop samples
      // pre-edge values; the synchroniser chain relies on this.
      s1 <= trig_i;
      s2 <= s1;
      s3 <= s2;

      ack_o <= access;
      if (access) dat_o <= rd_data;

      if (wr_en) begin
        case (adr_i)
          4'd0: begin
            arm       <= dat_i[0];
            edge_fall <= dat_i[1];
            auto_en   <= dat_i[2];
          end
          4'd1:    delay_reg[7:0]  <= dat_i;
          4'd2:    delay_reg[15:8] <= dat_i;
          4'd3:    width_reg       <= dat_i;
          4'd4:    hold_reg        <= dat_i;
          default: ;
        endcase
      end

      if (count_clr)     count <= 8'h00;
      else if (fire_end) count <= count + 8'd1;

      if (abort) begin
        state   <= ST_IDLE;
        run_o   <= 1'b0;
        armed_o <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_ARMED: begin
            if (state == ST_IDLE && arm_wr) done <= 1'b0;
            if (launch) begin
              wcnt    <= {width_reg == 8'd0, width_reg};
              hold_w  <= hold_reg;
              armed_o <= 1'b0;
              if (delay_reg == 16'd0) begin
                state <= ST_FIRE;
                run_o <= 1'b1;
              end else begin
                state <= ST_DELAY;
                dcnt  <= delay_reg;
              end
            end else if (state == ST_IDLE && arm_wr) begin
              state   <= ST_ARMED;
              armed_o <= 1'b1;
            end
          end
          ST_DELAY: begin
            if (dcnt == 16'd1) begin
              state <= ST_FIRE;
              run_o <= 1'b1;
            end else begin
              dcnt <= dcnt - 16'd1;
            end
          end
          ST_FIRE: begin
            if (wcnt == 9'd1) begin
              run_o <= 1'b0;
              if (hold_w != 8'd0) begin
                state <= ST_HOLD;
                hcnt  <= hold_w;
              end
            end else begin
              wcnt <= wcnt - 9'd1;
            end
          end
          ST_HOLD: begin
            if (hcnt != 8'd1) hcnt <= hcnt - 8'd1;
          end
          default: begin
            state   <= ST_IDLE;
            run_o   <= 1'b0;
            armed_o <= 1'b0;
          end
        endcase

        // Re-arm decision; placed last so it overrides the CTRL bus write
        // of ARM on the same edge.
        if (rearm_pt) begin
          if (auto_en && arm) begin
            state   <= ST_ARMED;
            armed_o <= 1'b1;
          end else begin
            state   <= ST_IDLE;
            armed_o <= 1'b0;
            done    <= 1'b1;
            arm     <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_deja_glitch_trigger.sv
// Directed testbench for deja_glitch_trigger. Inputs are driven and outputs
// sampled 1 ns after each rising clock edge.
module tb_deja_glitch_trigger;

  logic       clk;
  logic       rst;
  logic       stb;
  logic       we;
  logic [3:0] adr;
  logic [7:0] dat_w;
  logic       ack;
  logic [7:0] dat_r;
  logic       trig;
  logic       run;
  logic       armed;

  int n_assert = 0;
  int n_fail   = 0;

  deja_glitch_trigger dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .stb_i   (stb),
    .we_i    (we),
    .adr_i   (adr),
    .dat_i   (dat_w),
    .ack_o   (ack),
    .dat_o   (dat_r),
    .trig_i  (trig),
    .run_o   (run),
    .armed_o (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // The write lands on the first edge (the acking edge); the second tick
  // lets ack fall so the next access is serviced.
  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    stb = 1'b1; we = 1'b1; adr = a; dat_w = d;
    tick();
    stb = 1'b0; we = 1'b0;
    tick();
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
    stb = 1'b1; we = 1'b0; adr = a;
    tick();
    check({tag, "_ack"}, {15'd0, ack}, 16'd1);
    check(tag, {8'd0, dat_r}, {8'd0, exp});
    stb = 1'b0;
    tick();
    check({tag, "_ack_drop"}, {15'd0, ack}, 16'd0);
    check({tag, "_hold"}, {8'd0, dat_r}, {8'd0, exp});
  endtask

  // Trigger level for edge i of one auto-rearm shot: falling at 0 (real
  // event), rising at 2, falling at 4 (during FIRE), rising at 7, falling
  // at 8 (during HOLD), then high again from 40 for the next shot.
  function automatic logic shot_trig(input int i);
    if (i < 2)  return 1'b0;
    if (i < 4)  return 1'b1;
    if (i < 7)  return 1'b0;
    if (i == 7) return 1'b1;
    if (i < 40) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    int hi;
    int first;

    rst = 1'b1; stb = 1'b0; we = 1'b0; adr = 4'd0; dat_w = 8'd0; trig = 1'b0;
    ticks(3);
    rst = 1'b0;
    tick();

    // ---- Reset state and register defaults ----
    check("rst_run",   {15'd0, run},   16'd0);
    check("rst_armed", {15'd0, armed}, 16'd0);
    check("rst_ack",   {15'd0, ack},   16'd0);
    check("rst_dat",   {8'd0, dat_r},  16'd0);
    bus_read(4'd0, 8'h00, "rst_ctrl");
    bus_read(4'd1, 8'h00, "rst_delay_lo");
    bus_read(4'd2, 8'h00, "rst_delay_hi");
    bus_read(4'd3, 8'h01, "rst_width");
    bus_read(4'd4, 8'h00, "rst_holdoff");
    bus_read(4'd5, 8'h00, "rst_status");
    bus_read(4'd6, 8'h00, "rst_count");
    bus_write(4'd7, 8'hFF);
    bus_read(4'd7, 8'h00, "unmapped");

    // ---- Basic shot: DELAY=5, WIDTH=3 ----
    bus_write(4'd1, 8'd5);
    bus_write(4'd3, 8'd3);
    bus_write(4'd0, 8'h01);
    check("arm_armed", {15'd0, armed}, 16'd1);
    bus_read(4'd5, 8'h21, "arm_status");
    trig = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      tick();
      check($sformatf("basic_run_k%0d", i), {15'd0, run}, {15'd0, (i >= 7 && i <= 9)});
      if (i == 1) check("basic_armed_k1", {15'd0, armed}, 16'd1);
      if (i == 2) check("basic_armed_k2", {15'd0, armed}, 16'd0);
    end
    trig = 1'b0;
    bus_read(4'd6, 8'd1, "basic_count");
    bus_read(4'd5, 8'h08, "basic_status");
    bus_read(4'd0, 8'h00, "basic_ctrl");

    // ---- Soft trigger, DELAY=0, WIDTH=0 (256 clocks) ----
    bus_write(4'd1, 8'd0);
    bus_write(4'd3, 8'd0);
    stb = 1'b1; we = 1'b1; adr = 4'd0; dat_w = 8'h09;
    tick();
    check("soft_run_ack_edge", {15'd0, run}, 16'd1);
    check("soft_ack", {15'd0, ack}, 16'd1);
    stb = 1'b0; we = 1'b0;
    hi = 1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!run) break;
      hi++;
    end
    check("soft_width", hi[15:0], 16'd256);
    bus_read(4'd6, 8'd2, "soft_count");
    bus_read(4'd5, 8'h08, "soft_status");

    // ---- Auto re-arm, falling edge, HOLDOFF=4, stray edges ignored ----
    bus_write(4'd1, 8'd2);
    bus_write(4'd3, 8'd3);
    bus_write(4'd4, 8'd4);
    bus_write(4'd6, 8'h55);
    bus_read(4'd6, 8'd0, "auto_count_clr");
    trig = 1'b1;
    ticks(5);
    bus_write(4'd0, 8'h07);
    for (int s = 0; s < 3; s++) begin
      hi = 0;
      first = -1;
      for (int i = 0; i < 50; i++) begin
        trig = shot_trig(i);
        tick();
        if (run) begin
          hi++;
          if (first < 0) first = i;
        end
      end
      check($sformatf("auto_shot%0d_high", s), hi[15:0], 16'd3);
      check($sformatf("auto_shot%0d_rise", s), first[15:0], 16'd4);
      check($sformatf("auto_shot%0d_rearmed", s), {15'd0, armed}, 16'd1);
    end
    bus_read(4'd6, 8'd3, "auto_count");
    bus_read(4'd5, 8'h21, "auto_status");

    // ---- Abort during DELAY ----
    bus_write(4'd0, 8'h01);
    bus_write(4'd1, 8'd100);
    trig = 1'b0;
    ticks(4);
    check("abort_d_still_armed", {15'd0, armed}, 16'd1);
    trig = 1'b1;
    hi = 0;
    for (int i = 0; i <= 41; i++) begin
      tick();
      if (run) hi++;
      if (i == 2) check("abort_d_armed_k2", {15'd0, armed}, 16'd0);
    end
    bus_write(4'd0, 8'h00);
    for (int i = 0; i < 120; i++) begin
      tick();
      if (run) hi++;
    end
    check("abort_d_no_run", hi[15:0], 16'd0);
    bus_read(4'd5, 8'h00, "abort_d_status");
    bus_read(4'd6, 8'd3, "abort_d_count");

    // ---- Abort during FIRE ----
    bus_write(4'd1, 8'd3);
    bus_write(4'd3, 8'd20);
    bus_write(4'd0, 8'h01);
    trig = 1'b0;
    ticks(4);
    trig = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      tick();
      if (i == 4) check("abort_f_run_k4", {15'd0, run}, 16'd0);
      if (i == 6) check("abort_f_run_k6", {15'd0, run}, 16'd1);
    end
    stb = 1'b1; we = 1'b1; adr = 4'd0; dat_w = 8'h00;
    tick();
    check("abort_f_run_drop", {15'd0, run}, 16'd0);
    check("abort_f_ack", {15'd0, ack}, 16'd1);
    stb = 1'b0; we = 1'b0;
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (run) hi++;
    end
    check("abort_f_stay_low", hi[15:0], 16'd0);
    bus_read(4'd6, 8'd3, "abort_f_count");
    bus_read(4'd5, 8'h00, "abort_f_status");

    // ---- Reset during FIRE ----
    bus_write(4'd0, 8'h01);
    trig = 1'b0;
    ticks(4);
    trig = 1'b1;
    ticks(7);
    check("rstf_run_before", {15'd0, run}, 16'd1);
    rst = 1'b1;
    tick();
    check("rstf_run",   {15'd0, run},   16'd0);
    check("rstf_armed", {15'd0, armed}, 16'd0);
    check("rstf_dat",   {8'd0, dat_r},  16'd0);
    rst = 1'b0;
    tick();
    bus_read(4'd0, 8'h00, "rstf_ctrl");
    bus_read(4'd1, 8'h00, "rstf_delay_lo");
    bus_read(4'd3, 8'h01, "rstf_width");
    bus_read(4'd4, 8'h00, "rstf_holdoff");
    bus_read(4'd5, 8'h00, "rstf_status");
    bus_read(4'd6, 8'h00, "rstf_count");
    hi = 0;
    trig = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); if (run) hi++; end
    trig = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); if (run) hi++; end
    check("rstf_ignore_trig", hi[15:0], 16'd0);
    check("rstf_not_armed", {15'd0, armed}, 16'd0);

    // Re-arm after reset with defaults: DELAY=0, WIDTH=1.
    bus_write(4'd0, 8'h01);
    trig = 1'b0;
    ticks(4);
    trig = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      tick();
      if (i >= 1) check($sformatf("rearm_run_k%0d", i), {15'd0, run}, {15'd0, i == 2});
    end
    bus_read(4'd6, 8'd1, "rearm_count");
    bus_read(4'd5, 8'h08, "rearm_status");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
